ripple_adder: RTL and testbench



---
 rtl/ripple_adder_pkg.sv | 9 +
 rtl/ripple_adder_full_adder.sv | 27 ++
 rtl/ripple_adder.sv | 59 +++++
 tb/tb_ripple_adder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ripple_adder_pkg.sv
// ripple_adder_pkg
//   Shared constants for the ripple_adder block.
//   DEFAULT_WIDTH : default operand/sum width of ripple_adder (40 bits).
//   Nothing else is shared. The width itself remains a parameter of the top module.
package ripple_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 40;

endpackage : ripple_adder_pkg

// File: rtl/ripple_adder_full_adder.sv
// full_adder
//   Purely combinational 1-bit full adder. It is the cell that ripple_adder
//   chains, one cell per bit.
//   Ports:
//     a, b : operand bits
//     cin  : carry in from the next-lower bit
//     s    : sum bit = a ^ b ^ cin
//     cout : carry out to the next-higher bit
module full_adder
  import ripple_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  // The propagate term a^b is shared by the sum and the carry. The carry is
  // then either generated locally (a&b) or propagated from cin.
  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/ripple_adder.sv
// ripple_adder
//   WIDTH-bit unsigned adder: {C_out, S} = A + B + C_in. The carry ripples
//   bit-serially through a chain of full_adder cells, and one register stage
//   captures the result. The latency is 1 cycle and the block accepts new
//   operands every cycle. There is no handshake.
//   Parameters:
//     WIDTH : operand/sum width, >= 1 (default 40)
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset; clears S and C_out
//     A, B  : unsigned operands
//     C_in  : carry into bit 0
//     S     : registered sum bits [WIDTH-1:0]
//     C_out : registered carry out of bit WIDTH-1
module ripple_adder
  import ripple_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  // c[i] is the carry into bit i. c[WIDTH] is the final carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = C_in;

  // Plain ripple chain. There is deliberately no lookahead: the block trades
  // timing for the smallest possible adder.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end : g_bit

  // Output register. Reset clears it without waiting for a clock edge, so any
  // in-flight result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S     <= '0;
      C_out <= 1'b0;
    end else begin
      S     <= sum;
      C_out <= c[WIDTH];
    end
  end

endmodule : ripple_adder

// File: tb/tb_ripple_adder.sv
// tb_ripple_adder
//   Self-checking bench for ripple_adder at WIDTH = 40.
//   A table of directed vectors and a stream of random vectors are driven
//   back to back. Each expected {C_out, S} is pushed to a queue when its
//   operands are driven. It is popped and compared one cycle later. Hand-written
//   sequences cover the asynchronous reset, both at start-up and mid-stream.
module tb_ripple_adder;

  localparam int unsigned W         = 40;
  localparam int          N_RANDOM  = 10000;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   expected;
    string        name;
  } vector_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         C_in = 1'b0;
  logic [W-1:0] S;
  logic         C_out;

  int checks   = 0;
  int failures = 0;

  logic [W:0]   expected_q [$];
  string        name_q     [$];
  vector_t      vectors    [10];

  ripple_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out)
  );

  // The first rising edge is at 5 ns. Every later rising edge is 10 ns after the previous one.
  initial forever #5 clk = ~clk;

  // Compares the DUT output against one expected {C_out, S} value.
  task automatic check(input string name, input logic [W:0] expected);
    checks++;
    if ({C_out, S} !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got C_out=%0b S=%h, expected C_out=%0b S=%h",
               name, C_out, S, expected[W], expected[W-1:0]);
    end
  endtask

  // Independent model: a plain (W+1)-bit addition.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Called at a falling edge. It first retires the result registered at the
  // preceding rising edge, then drives the next operands and records their
  // expected result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic [W:0] expected,
                               input string name);
    checkOutput();
    A    = a;
    B    = b;
    C_in = cin;
    expected_q.push_back(expected);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    if (expected_q.size() != 0) begin
      logic [W:0] e;
      string      n;
      e = expected_q.pop_front();
      n = name_q.pop_front();
      check(n, e);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    vectors[0] = '{40'd11,          40'd1111,        1'b0, 41'd1122,              "small_sum"};
    vectors[1] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 41'h1_FF_FFFF_FFFF,   "ones_ones_cin1"};
    vectors[2] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b0, 41'h1_FF_FFFF_FFFE,   "ones_ones_cin0"};
    vectors[3] = '{40'hFF_FFFF_FFFF, 40'h0,            1'b1, 41'h1_00_0000_0000,   "full_ripple"};
    vectors[4] = '{40'h0,            40'h0,            1'b0, 41'h0,                "zero"};
    vectors[5] = '{40'h0,            40'h0,            1'b1, 41'h1,                "cin_only"};
    vectors[6] = '{40'hAA_AAAA_AAAA, 40'h55_5555_5555, 1'b1, 41'h1_00_0000_0000,   "alt_ripple"};
    vectors[7] = '{40'h80_0000_0000, 40'h80_0000_0000, 1'b0, 41'h1_00_0000_0000,   "msb_carry"};
    vectors[8] = '{40'h7F_FFFF_FFFF, 40'h1,            1'b0, 41'h0_80_0000_0000,   "into_msb"};
    vectors[9] = '{40'h12_3456_789A, 40'h0F_EDCB_A987, 1'b0, 41'h0_22_2222_2221,   "mixed"};

    // Start-up reset: the outputs must clear before any clock edge.
    A = 40'd5;
    B = 40'd5;
    #1 rst_n = 1'b0;
    #1 check("reset_no_clock", '0);
    @(negedge clk);
    check("reset_held", '0);
    rst_n = 1'b1;

    // Directed table, driven back to back.
    foreach (vectors[i])
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin,
                    vectors[i].expected, vectors[i].name);

    // Random stream with a reset pulse in the middle.
    for (int i = 0; i < N_RANDOM; i++) begin
      if (i == N_RANDOM / 2) begin
        checkOutput();
        rst_n = 1'b0;
        #1 check("reset_mid_async", '0);
        @(negedge clk);
        check("reset_mid_held", '0);
        rst_n = 1'b1;
      end
      ra = {$urandom_range(255, 0), $urandom()};
      rb = {$urandom_range(255, 0), $urandom()};
      rc = 1'($urandom_range(1, 0));
      applyStimulus(ra, rb, rc, model(ra, rb, rc), "random");
    end
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_ripple_adder
